// File: rtl/mmb_wrr_arbitrator.sv
// Weighted round-robin arbiter that merges N burst-capable masters onto one slave port.
// Write bursts lock the port; read commands are tagged in an in-order FIFO to steer responses back.
module mmb_wrr_arbitrator #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int BWIDTH  = 4,
  parameter int MASTERS = 4,
  parameter int RDPENDS = 4,
  parameter int WEIGHT  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [MASTERS*AWIDTH-1:0] s_addr,
  input  logic [MASTERS*BWIDTH-1:0] s_bcnt,
  input  logic [MASTERS-1:0]        s_wreq,
  input  logic [MASTERS*DWIDTH-1:0] s_wdat,
  input  logic [MASTERS-1:0]        s_rreq,
  output logic [MASTERS*DWIDTH-1:0] s_rdat,
  output logic [MASTERS-1:0]        s_rval,
  output logic [MASTERS-1:0]        s_busy,
  output logic [AWIDTH-1:0]         m_addr,
  output logic [BWIDTH-1:0]         m_bcnt,
  output logic                      m_wreq,
  output logic [DWIDTH-1:0]         m_wdat,
  output logic                      m_rreq,
  input  logic [DWIDTH-1:0]         m_rdat,
  input  logic                      m_rval,
  input  logic                      m_busy
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int PW = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
  localparam int CW = $clog2(RDPENDS + 1);
  localparam int KW = $clog2(WEIGHT + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] WBURST = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [MW-1:0]      owner_q, owner_d, ptr_q, ptr_d, last_q, last_d;
  logic               lastv_q, lastv_d;
  logic [KW-1:0]      credit_q, credit_d;
  logic [BWIDTH-1:0]  cnt_q, cnt_d, rcnt_q;
  logic [PW-1:0]      wp_q, rp_q;
  logic [CW-1:0]      fcnt_q;
  logic [MASTERS-1:0] fm_q [RDPENDS];
  logic [BWIDTH-1:0]  fb_q [RDPENDS];
  logic [DWIDTH-1:0]  rdat_q;
  logic [MASTERS-1:0] rval_q;

  logic [AWIDTH-1:0]  addr_a [MASTERS];
  logic [BWIDTH-1:0]  bcnt_a [MASTERS];
  logic [DWIDTH-1:0]  wdat_a [MASTERS];
  logic [MASTERS-1:0] req;
  logic [MW-1:0]      win, sel, cand;
  logic               win_vld, wr, rd, empty, full, pop, rd_block, w_acc, r_acc, cmd_acc;

  function automatic logic [MW-1:0] mnext(input logic [MW-1:0] m);
    return (int'(m) == MASTERS - 1) ? '0 : m + 1'b1;
  endfunction

  function automatic logic [PW-1:0] pnext(input logic [PW-1:0] p);
    return (int'(p) == RDPENDS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      addr_a[i] = s_addr[i*AWIDTH +: AWIDTH];
      bcnt_a[i] = s_bcnt[i*BWIDTH +: BWIDTH];
      wdat_a[i] = s_wdat[i*DWIDTH +: DWIDTH];
    end
  end

  // Requests are masked while reset is held so every output sits at its reset value.
  assign req      = (s_wreq | s_rreq) & {MASTERS{reset_n}};
  assign empty    = (fcnt_q == '0);
  assign full     = (fcnt_q == CW'(RDPENDS));
  assign pop      = m_rval && !empty && (rcnt_q == fb_q[rp_q]);
  assign rd_block = full && !pop;

  // The last winner keeps priority while it still has credit; otherwise search from the pointer.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    if (lastv_q && req[last_q] && credit_q > KW'(1)) begin
      win_vld = 1'b1;
      win     = last_q;
    end else begin
      for (int i = MASTERS - 1; i >= 0; i--) begin
        cand = MW'((int'(ptr_q) + i) % MASTERS);
        if (req[cand]) begin
          win_vld = 1'b1;
          win     = cand;
        end
      end
    end
  end

  assign sel = (state_q == WBURST) ? owner_q : win;

  always_comb begin
    m_addr = '0;
    m_bcnt = '0;
    m_wdat = '0;
    m_wreq = 1'b0;
    m_rreq = 1'b0;
    s_busy = '1;
    wr     = 1'b0;
    rd     = 1'b0;
    if (state_q == WBURST || win_vld) begin
      wr          = s_wreq[sel];
      rd          = (state_q == IDLE) && s_rreq[sel] && !wr;
      m_addr      = addr_a[sel];
      m_bcnt      = (bcnt_a[sel] == '0) ? BWIDTH'(1) : bcnt_a[sel];
      m_wdat      = wdat_a[sel];
      m_wreq      = wr;
      m_rreq      = rd && !rd_block;
      s_busy[sel] = m_busy || (rd && rd_block);
    end
  end

  assign w_acc   = m_wreq && !m_busy;
  assign r_acc   = m_rreq && !m_busy;
  assign cmd_acc = (state_q == IDLE) && (w_acc || r_acc);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (w_acc && m_bcnt > BWIDTH'(1)) begin
        state_d = WBURST;
        owner_d = win;
        cnt_d   = m_bcnt - 1'b1;
      end
    end else if (w_acc) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == BWIDTH'(1)) state_d = IDLE;
    end
  end

  // A write burst is charged once, on its first beat, since only IDLE-state accepts count.
  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    last_d   = last_q;
    lastv_d  = lastv_q;
    if (cmd_acc) begin
      if (lastv_q && win == last_q && credit_q > KW'(1)) begin
        credit_d = credit_q - 1'b1;
      end else begin
        ptr_d    = mnext(win);
        credit_d = KW'(WEIGHT);
      end
      last_d  = win;
      lastv_d = 1'b1;
    end else if (state_q == IDLE && lastv_q && !req[last_q]) begin
      ptr_d    = mnext(last_q);
      credit_d = KW'(WEIGHT);
      lastv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_acc) begin
      fm_q[wp_q] <= MASTERS'(1) << win;
      fb_q[wp_q] <= m_bcnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      last_q   <= '0;
      lastv_q  <= 1'b0;
      credit_q <= KW'(WEIGHT);
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      rcnt_q   <= BWIDTH'(1);
      rdat_q   <= '0;
      rval_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      lastv_q  <= lastv_d;
      credit_q <= credit_d;
      if (r_acc) wp_q <= pnext(wp_q);
      if (pop)   rp_q <= pnext(rp_q);
      case ({r_acc, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      if (m_rval && !empty) rcnt_q <= pop ? BWIDTH'(1) : rcnt_q + 1'b1;
      rdat_q <= m_rdat;
      rval_q <= fm_q[rp_q] & {MASTERS{m_rval && !empty}};
    end
  end

  assign s_rdat = {MASTERS{rdat_q}};
  assign s_rval = rval_q;

endmodule

// File: tb/tb_mmb_wrr_arbitrator.sv
// Directed bench for mmb_wrr_arbitrator: WRR grant order, burst locking with stalls,
// tag-FIFO backpressure and read steering, and reset in the middle of traffic.
module tb_mmb_wrr_arbitrator;
  localparam int AW = 8, DW = 8, BW = 4, M = 4, RP = 2, WT = 2;

  logic            clk;
  logic            reset_n;
  logic [M*AW-1:0] s_addr;
  logic [M*BW-1:0] s_bcnt;
  logic [M-1:0]    s_wreq;
  logic [M*DW-1:0] s_wdat;
  logic [M-1:0]    s_rreq;
  logic [M*DW-1:0] s_rdat;
  logic [M-1:0]    s_rval;
  logic [M-1:0]    s_busy;
  logic [AW-1:0]   m_addr;
  logic [BW-1:0]   m_bcnt;
  logic            m_wreq;
  logic [DW-1:0]   m_wdat;
  logic            m_rreq;
  logic [DW-1:0]   m_rdat;
  logic            m_rval;
  logic            m_busy;

  int ntest = 0;
  int nfail = 0;

  mmb_wrr_arbitrator #(
    .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .MASTERS(M), .RDPENDS(RP), .WEIGHT(WT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_addr(s_addr), .s_bcnt(s_bcnt), .s_wreq(s_wreq), .s_wdat(s_wdat), .s_rreq(s_rreq),
    .s_rdat(s_rdat), .s_rval(s_rval), .s_busy(s_busy),
    .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
    .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [DW-1:0] d);
    s_wreq[i]           = wr;
    s_rreq[i]           = rd;
    s_addr[i*AW +: AW]  = a;
    s_bcnt[i*BW +: BW]  = b;
    s_wdat[i*DW +: DW]  = d;
  endtask

  task automatic clear_in();
    s_addr = '0; s_bcnt = '0; s_wreq = '0; s_wdat = '0; s_rreq = '0;
    m_rdat = '0; m_rval = 1'b0; m_busy = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int          eg [9];
    int          beats;
    logic [3:0]  eb;

    eg = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", s_busy, 4'hF);
    chk("rst_mwreq", m_wreq, 1'b0);
    chk("rst_mrreq", m_rreq, 1'b0);
    chk("rst_maddr", m_addr, 8'h00);
    chk("rst_srval", s_rval, 4'h0);
    chk("rst_srdat", s_rdat, 32'h0);
    reset_n = 1'b1;

    // Weighted round-robin with everyone writing single beats.
    for (int i = 0; i < M; i++) set_m(i, 1'b1, 1'b0, AW'(16 * i), 4'd1, DW'(8'hA0 + i));
    for (int k = 0; k < 9; k++) begin
      #1;
      eb = ~(4'b0001 << eg[k]);
      chk("t1_busy", s_busy, eb);
      chk("t1_wdat", m_wdat, 8'hA0 + eg[k]);
      cyc();
    end

    // Four-beat burst from M0 holds off M1.
    do_reset();
    set_m(0, 1'b1, 1'b0, 8'h10, 4'd4, 8'h00);
    set_m(1, 1'b1, 1'b0, 8'h20, 4'd1, 8'h55);
    #1;
    chk("t2_busy_b0", s_busy, 4'b1110);
    chk("t2_bcnt", m_bcnt, 4'd4);
    chk("t2_addr", m_addr, 8'h10);
    cyc();
    for (int b = 1; b < 4; b++) begin
      s_wdat[7:0] = DW'(b);
      #1;
      chk("t2_busy_bn", s_busy, 4'b1110);
      chk("t2_wdat", m_wdat, b);
      chk("t2_wreq", m_wreq, 1'b1);
      cyc();
    end
    set_m(0, 1'b0, 1'b0, 8'h10, 4'd4, 8'h00);
    #1;
    chk("t2_m1_grant", s_busy, 4'b1101);
    chk("t2_m1_addr", m_addr, 8'h20);
    chk("t2_m1_wdat", m_wdat, 8'h55);
    cyc();

    // Three-beat burst from M2 against a stalling slave, M3 waiting.
    do_reset();
    set_m(2, 1'b1, 1'b0, 8'h30, 4'd3, 8'hC0);
    set_m(3, 1'b1, 1'b0, 8'h40, 4'd1, 8'hD0);
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      m_busy = (c % 2 == 0);
      s_wdat[2*DW +: DW] = DW'(8'hC0 + c);
      #1;
      eb = m_busy ? 4'hF : 4'b1011;
      chk("t3_busy", s_busy, eb);
      chk("t3_wdat", m_wdat, 8'hC0 + c);
      if (m_wreq && !m_busy) beats++;
      cyc();
    end
    chk("t3_beats", beats, 3);
    set_m(2, 1'b0, 1'b0, 8'h30, 4'd3, 8'hC0);
    m_busy = 1'b0;
    #1;
    chk("t3_m3_grant", s_busy, 4'b0111);
    chk("t3_m3_addr", m_addr, 8'h40);
    cyc();

    // Tag FIFO fills (depth 2) and M3 waits for the first pop.
    do_reset();
    set_m(1, 1'b0, 1'b1, 8'h51, 4'd2, 8'h00);
    #1;
    chk("t4_m1_busy", s_busy, 4'b1101);
    chk("t4_m1_rreq", m_rreq, 1'b1);
    chk("t4_m1_bcnt", m_bcnt, 4'd2);
    cyc();
    set_m(1, 1'b0, 1'b0, 8'h51, 4'd2, 8'h00);
    set_m(2, 1'b0, 1'b1, 8'h52, 4'd1, 8'h00);
    #1;
    chk("t4_m2_busy", s_busy, 4'b1011);
    chk("t4_m2_rreq", m_rreq, 1'b1);
    cyc();
    set_m(2, 1'b0, 1'b0, 8'h52, 4'd1, 8'h00);
    set_m(3, 1'b0, 1'b1, 8'h53, 4'd1, 8'h00);
    #1;
    chk("t4_m3_full_busy", s_busy, 4'hF);
    chk("t4_m3_full_rreq", m_rreq, 1'b0);
    cyc();
    m_rval = 1'b1;
    m_rdat = 8'h71;
    #1;
    chk("t4_m3_still_busy", s_busy, 4'hF);
    cyc();
    m_rdat = 8'h72;
    #1;
    chk("t4_m3_on_pop", s_busy, 4'b0111);
    chk("t4_m3_rreq", m_rreq, 1'b1);
    chk("t4_rval1", s_rval, 4'b0010);
    chk("t4_rdat1", s_rdat, 32'h71717171);
    cyc();
    set_m(3, 1'b0, 1'b0, 8'h53, 4'd1, 8'h00);
    m_rdat = 8'h73;
    #1;
    chk("t4_rval2", s_rval, 4'b0010);
    chk("t4_rdat2", s_rdat, 32'h72727272);
    cyc();
    m_rval = 1'b0;
    set_m(0, 1'b0, 1'b1, 8'h54, 4'd1, 8'h00);
    #1;
    chk("t4_rval3", s_rval, 4'b0100);
    chk("t4_rdat3", s_rdat, 32'h73737373);
    chk("t4_m0_busy", s_busy, 4'b1110);
    cyc();

    // Full FIFO: final beat of the head and a new read in the same cycle.
    set_m(0, 1'b0, 1'b0, 8'h54, 4'd1, 8'h00);
    set_m(1, 1'b0, 1'b1, 8'h55, 4'd1, 8'h00);
    m_rval = 1'b1;
    m_rdat = 8'h81;
    #1;
    chk("t5_pushpop_busy", s_busy, 4'b1101);
    chk("t5_pushpop_rreq", m_rreq, 1'b1);
    chk("t5_rval_idle", s_rval, 4'h0);
    cyc();
    set_m(1, 1'b0, 1'b0, 8'h55, 4'd1, 8'h00);
    set_m(2, 1'b0, 1'b1, 8'h56, 4'd1, 8'h00);
    m_rval = 1'b0;
    #1;
    chk("t5_rval_m3", s_rval, 4'b1000);
    chk("t5_rdat_m3", s_rdat, 32'h81818181);
    chk("t5_still_full", s_busy, 4'hF);
    chk("t5_still_full_rreq", m_rreq, 1'b0);
    cyc();
    m_rval = 1'b1;
    m_rdat = 8'h82;
    #1;
    chk("t5_m2_on_pop", s_busy, 4'b1011);
    cyc();
    set_m(2, 1'b0, 1'b0, 8'h56, 4'd1, 8'h00);
    m_rval = 1'b0;
    #1;
    chk("t5_rval_m0", s_rval, 4'b0001);
    chk("t5_rdat_m0", s_rdat, 32'h82828282);
    cyc();

    // Reset in the middle of a write burst with two reads outstanding.
    set_m(0, 1'b1, 1'b0, 8'h60, 4'd4, 8'hE0);
    #1;
    chk("t6_burst_b0", s_busy, 4'b1110);
    cyc();
    #1;
    chk("t6_burst_b1", s_busy, 4'b1110);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", s_busy, 4'hF);
    chk("t6_rst_wreq", m_wreq, 1'b0);
    chk("t6_rst_addr", m_addr, 8'h00);
    chk("t6_rst_bcnt", m_bcnt, 4'h0);
    chk("t6_rst_wdat", m_wdat, 8'h00);
    chk("t6_rst_rval", s_rval, 4'h0);
    cyc();
    set_m(0, 1'b0, 1'b0, 8'h60, 4'd4, 8'hE0);
    reset_n = 1'b1;
    m_rval  = 1'b1;
    m_rdat  = 8'h91;
    #1;
    chk("t6_post_busy", s_busy, 4'hF);
    cyc();
    m_rval = 1'b0;
    #1;
    chk("t6_rval_dropped", s_rval, 4'h0);
    cyc();
    set_m(1, 1'b0, 1'b1, 8'h57, 4'd1, 8'h00);
    #1;
    chk("t6_m1_read_busy", s_busy, 4'b1101);
    chk("t6_m1_read_rreq", m_rreq, 1'b1);
    cyc();
    set_m(1, 1'b0, 1'b0, 8'h57, 4'd1, 8'h00);
    m_rval = 1'b1;
    m_rdat = 8'h92;
    #1;
    cyc();
    m_rval = 1'b0;
    #1;
    chk("t6_m1_rval", s_rval, 4'b0010);
    chk("t6_m1_rdat", s_rdat, 32'h92929292);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
